// File: rtl/xyolo_read_sched_if.sv
// Handshake bundles for the read scheduler: the CPU command stream
// and the read-unit config/run/done pins.
interface xyolo_cmd_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready
  );
endinterface

interface xyolo_cfg_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          cfg_valid;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_wstrb;
  logic          run;
  logic          done;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_wdata,
    output cfg_wstrb,
    output run,
    input  done
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_wdata,
    input  cfg_wstrb,
    input  run,
    output done
  );
endinterface

// File: rtl/xyolo_read_sched.sv
// Command FIFO sequencer for the YOLO weight/bias read unit: replays
// config writes and gates run pulses on read-unit done.
module xyolo_read_sched #(
  parameter int CFG_ADDR_W = 5,
  parameter int CFG_DATA_W = 32,
  parameter int FIFO_AW    = 4,
  parameter int DONE_MASK  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  xyolo_cmd_if.slave  cmd,
  xyolo_cfg_if.master cfg,
  output logic        busy,
  output logic        sync_irq,
  output logic [15:0] run_count,
  output logic        err
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int MW =
    (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_RUN   = 2'b01,
    OP_SYNC  = 2'b10,
    OP_RSV   = 2'b11
  } op_e;

  typedef struct packed {
    op_e                   op;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cmd_t;

  cmd_t               mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  logic full, empty;
  logic push, pop;
  cmd_t head, wr_ent;

  logic                  busy_q, busy_d;
  logic [MW-1:0]         mask_q, mask_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic [CFG_ADDR_W-1:0] cfg_addr_q, cfg_addr_d;
  logic [CFG_DATA_W-1:0] cfg_wdata_q, cfg_wdata_d;
  logic                  run_q, run_d;
  logic                  sync_q, sync_d;
  logic [15:0]           rcnt_q, rcnt_d;
  logic                  err_q, err_d;

  logic is_wr, is_run, is_sync, is_rsv;
  logic issue_run;

  assign full  = cnt_q == (FIFO_AW + 1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push  = cmd.cmd_valid && !full && !clear;
  assign head  = mem_q[rptr_q];

  assign wr_ent.op   = op_e'(cmd.cmd_op);
  assign wr_ent.addr = cmd.cmd_addr;
  assign wr_ent.data = cmd.cmd_data;

  assign is_wr   = head.op == OP_WRITE;
  assign is_run  = head.op == OP_RUN;
  assign is_sync = head.op == OP_SYNC;
  assign is_rsv  = head.op == OP_RSV;

  // One head decision per cycle; clear drops it.
  always_comb begin
    pop         = 1'b0;
    issue_run   = 1'b0;
    cfg_valid_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_wdata_d = cfg_wdata_q;
    run_d       = 1'b0;
    sync_d      = 1'b0;
    err_d       = err_q;
    if (!empty && !clear) begin
      unique case (1'b1)
        is_wr: begin
          pop         = 1'b1;
          cfg_valid_d = 1'b1;
          cfg_addr_d  = head.addr;
          cfg_wdata_d = head.data;
        end
        is_run: begin
          if (!busy_q) begin
            pop       = 1'b1;
            issue_run = 1'b1;
            run_d     = 1'b1;
          end
        end
        is_sync: begin
          if (!busy_q) begin
            pop    = 1'b1;
            sync_d = 1'b1;
          end
        end
        is_rsv: begin
          pop   = 1'b1;
          err_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (clear) begin
      err_d = 1'b0;
    end
  end

  // In-flight tracking survives clear so a later RUN still waits.
  always_comb begin
    busy_d = busy_q;
    mask_d = mask_q;
    if (mask_q != '0) begin
      mask_d = mask_q - MW'(1);
    end
    if (busy_q && mask_q == '0 && cfg.done) begin
      busy_d = 1'b0;
    end
    if (issue_run) begin
      busy_d = 1'b1;
      mask_d = MW'(DONE_MASK);
    end
  end

  always_comb begin
    rcnt_d = rcnt_q + {15'd0, issue_run};
    if (clear) begin
      rcnt_d = '0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + FIFO_AW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + (FIFO_AW + 1)'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - (FIFO_AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= wr_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mask_q      <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_wdata_q <= '0;
      run_q       <= 1'b0;
      sync_q      <= 1'b0;
      rcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      mask_q      <= mask_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_wdata_q <= cfg_wdata_d;
      run_q       <= run_d;
      sync_q      <= sync_d;
      rcnt_q      <= rcnt_d;
      err_q       <= err_d;
    end
  end

  assign cmd.cmd_ready = !full;
  assign cfg.cfg_valid = cfg_valid_q;
  assign cfg.cfg_wstrb = cfg_valid_q;
  assign cfg.cfg_addr  = cfg_addr_q;
  assign cfg.cfg_wdata = cfg_wdata_q;
  assign cfg.run       = run_q;
  assign busy          = busy_q || !empty;
  assign sync_irq      = sync_q;
  assign run_count     = rcnt_q;
  assign err           = err_q;

endmodule

// File: tb/tb_xyolo_read_sched.sv
// Directed scoreboard bench for xyolo_read_sched: config write order,
// run/sync timing against done, backpressure, clear and reset.
module tb_xyolo_read_sched;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DM = 2;

  localparam logic [1:0] W  = 2'b00;
  localparam logic [1:0] R  = 2'b01;
  localparam logic [1:0] S  = 2'b10;
  localparam logic [1:0] RV = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        busy;
  logic        sync_irq;
  logic [15:0] run_count;
  logic        err;

  xyolo_cmd_if #(.AW(AW), .DW(DW)) cmd ();
  xyolo_cfg_if #(.AW(AW), .DW(DW)) cfg ();

  xyolo_read_sched #(
    .CFG_ADDR_W(AW),
    .CFG_DATA_W(DW),
    .FIFO_AW(4),
    .DONE_MASK(DM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .cmd(cmd),
    .cfg(cfg),
    .busy(busy),
    .sync_irq(sync_irq),
    .run_count(run_count),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  wr_t exp_q[$];
  int  wr_cyc[$];
  int  run_cyc[$];
  int  sync_cyc[$];
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg.cfg_valid) begin
        wr_cyc.push_back(cyc);
        chk("cfg_wstrb", 64'(cfg.cfg_wstrb), 64'd1);
        if (exp_q.size() == 0) begin
          chk("cfg_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cfg_addr", 64'(cfg.cfg_addr), 64'(mon_e.a));
          chk("cfg_wdata", 64'(cfg.cfg_wdata), 64'(mon_e.d));
        end
      end
      if (cfg.run) begin
        run_cyc.push_back(cyc);
        chk("run_excl", 64'(cfg.cfg_valid), 64'd0);
      end
      if (sync_irq) sync_cyc.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op,
                      input logic [AW-1:0] a,
                      input logic [DW-1:0] d,
                      input bit ex);
    bit  ok;
    wr_t w;
    ok = 1'b0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_addr  = a;
    cmd.cmd_data  = d;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd.cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) cmd.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    if (ok) begin
      acc_cyc = cyc;
      if (ex && op == W) begin
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
      end
    end else begin
      chk("push_timeout", 64'd1, 64'd0);
    end
  endtask

  task automatic idle();
    cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int c);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    c = cyc;
    chk(tag, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_logs();
    wr_cyc.delete();
    run_cyc.delete();
    sync_cyc.delete();
  endtask

  initial begin
    int e0;
    int d0;
    int bi;
    wr_t w;
    rst = 1'b1;
    clear = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op = 2'b00;
    cmd.cmd_addr = '0;
    cmd.cmd_data = '0;
    cfg.done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd.cmd_ready), 64'd1);
    chk("rst_outs", 64'({cfg.cfg_valid, cfg.cfg_wstrb, cfg.run,
                         sync_irq, busy, err}), 64'd0);
    chk("rst_count", 64'(run_count), 64'd0);
    chk("rst_addr", 64'(cfg.cfg_addr), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic
    cfg.done = 1'b1;
    push(W, 5'd3, 32'h1000, 1'b1);
    e0 = acc_cyc;
    push(W, 5'd4, 32'h40, 1'b1);
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    @(negedge clk);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_idle("basic_idle", bi);
    chk("basic_nwr", 64'(wr_cyc.size()), 64'd2);
    chk("basic_wr0_t", 64'(wr_cyc[0]), 64'(e0 + 1));
    chk("basic_wr1_t", 64'(wr_cyc[1]), 64'(e0 + 2));
    chk("basic_nrun", 64'(run_cyc.size()), 64'd1);
    chk("basic_run_t", 64'(run_cyc[0]), 64'(e0 + 3));
    chk("basic_busy_end", 64'(bi), 64'(e0 + 6));
    chk("basic_count", 64'(run_count), 64'd1);

    // ping-pong
    clr_logs();
    cfg.done = 1'b0;
    push(R, 5'd0, 32'd0, 1'b1);
    push(W, 5'd1, 32'hA1, 1'b1);
    push(W, 5'd2, 32'hA2, 1'b1);
    push(W, 5'd3, 32'hA3, 1'b1);
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    tick(50);
    chk("pp_no_early_run", 64'(run_cyc.size()), 64'd1);
    d0 = cyc;
    cfg.done = 1'b1;
    wait_idle("pp_idle", bi);
    chk("pp_nwr", 64'(wr_cyc.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      chk("pp_wr_t", 64'(wr_cyc[k]), 64'(run_cyc[0] + k + 1));
    end
    chk("pp_nrun", 64'(run_cyc.size()), 64'd2);
    chk("pp_run2_t", 64'(run_cyc[1]), 64'(d0 + 2));
    chk("pp_count", 64'(run_count), 64'd3);

    // done masking
    clr_logs();
    push(R, 5'd0, 32'd0, 1'b1);
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    wait_idle("mask_idle", bi);
    chk("mask_nrun", 64'(run_cyc.size()), 64'd2);
    chk("mask_gap", 64'(run_cyc[1] - run_cyc[0]), 64'(DM + 2));

    // full / backpressure
    clr_logs();
    cfg.done = 1'b0;
    push(R, 5'd0, 32'd0, 1'b1);
    push(R, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      push(W, 5'(i), 32'h100 + 32'(i), 1'b1);
    end
    idle();
    @(negedge clk);
    chk("full_ready", 64'(cmd.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = W;
    cmd.cmd_addr = 5'd9;
    cmd.cmd_data = 32'hEE;
    w.a = 5'd9;
    w.d = 32'hEE;
    exp_q.push_back(w);
    tick(3);
    @(posedge clk);
    #1;
    d0 = cyc;
    cfg.done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("full_ready_hold", 64'(cmd.cmd_ready), 64'd0);
    @(negedge clk);
    chk("full_ready_rise", 64'(cmd.cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    idle();
    wait_idle("full_idle", bi);
    chk("full_nwr", 64'(wr_cyc.size()), 64'd16);
    chk("full_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("full_run2_t", 64'(run_cyc[1]), 64'(d0 + 2));

    // sync and reserved op
    clr_logs();
    cfg.done = 1'b0;
    push(R, 5'd0, 32'd0, 1'b1);
    push(S, 5'd0, 32'd0, 1'b1);
    idle();
    tick(20);
    chk("sync_early", 64'(sync_cyc.size()), 64'd0);
    d0 = cyc;
    cfg.done = 1'b1;
    wait_idle("sync_idle", bi);
    chk("sync_n", 64'(sync_cyc.size()), 64'd1);
    chk("sync_t", 64'(sync_cyc[0]), 64'(d0 + 2));
    chk("err_pre", 64'(err), 64'd0);
    push(RV, 5'd1, 32'h55, 1'b1);
    idle();
    tick(2);
    chk("err_set", 64'(err), 64'd1);
    push(W, 5'd7, 32'h77, 1'b1);
    idle();
    wait_idle("rsv_idle", bi);
    chk("err_sticky", 64'(err), 64'd1);
    chk("rsv_nwr", 64'(wr_cyc.size()), 64'd1);

    // clear mid-run
    clr_logs();
    cfg.done = 1'b0;
    push(R, 5'd0, 32'd0, 1'b1);
    push(R, 5'd0, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      push(W, 5'(i + 10), 32'hC0 + 32'(i), 1'b0);
    end
    clear = 1'b1;
    cmd.cmd_op = W;
    cmd.cmd_addr = 5'd20;
    cmd.cmd_data = 32'hDEAD;
    tick(1);
    clear = 1'b0;
    idle();
    @(negedge clk);
    chk("clr_count", 64'(run_count), 64'd0);
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_ready", 64'(cmd.cmd_ready), 64'd1);
    tick(10);
    chk("clr_busy_hold", 64'(busy), 64'd1);
    chk("clr_nwr", 64'(wr_cyc.size()), 64'd0);
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    tick(10);
    chk("clr_run_wait", 64'(run_cyc.size()), 64'd1);
    d0 = cyc;
    cfg.done = 1'b1;
    wait_idle("clr_idle", bi);
    chk("clr_nrun", 64'(run_cyc.size()), 64'd2);
    chk("clr_run_t", 64'(run_cyc[1]), 64'(d0 + 2));
    chk("clr_count2", 64'(run_count), 64'd1);

    // reset mid-operation
    cfg.done = 1'b0;
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    tick(3);
    chk("rst2_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_busy", 64'(busy), 64'd0);
    chk("rst2_count", 64'(run_count), 64'd0);
    chk("rst2_ready", 64'(cmd.cmd_ready), 64'd1);
    clr_logs();
    @(posedge clk);
    #1;
    push(R, 5'd0, 32'd0, 1'b1);
    idle();
    tick(3);
    chk("rst2_run", 64'(run_cyc.size()), 64'd1);
    chk("rst2_count1", 64'(run_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/xyolo_read_sched.md
Name: xyolo_read_sched

Overview:
- Command-driven sequencer for the YOLO weight/bias read unit.
- CPU pushes a stream of WRITE/RUN/SYNC commands into an internal FIFO. The block replays WRITEs onto the read unit's config bus and issues `run` pulses.
- It tracks read-unit `done` so the next tile's config is written during the current tile (shadow-register ping-pong) without a premature `run`.
- Sits between the CPU register interface and the read unit's valid/addr/wdata/wstrb/run/done pins.

Parameters:
- CFG_ADDR_W, 5, config register address width (matches read-unit addr port).
- CFG_DATA_W, 32, config write data width.
- FIFO_AW, 4, log2 of command FIFO depth (16 entries).
- DONE_MASK, 2, cycles after `run` during which `done` is ignored (covers read-unit run register plus addrgen start).

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- clear  in  1  synchronous soft flush
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  2  00 WRITE, 01 RUN, 10 SYNC, 11 reserved
- cmd_addr  in  CFG_ADDR_W  config register address (WRITE only)
- cmd_data  in  CFG_DATA_W  config value (WRITE only)
- cfg_valid  out  1  config write strobe to read unit
- cfg_addr  out  CFG_ADDR_W  config address
- cfg_wdata  out  CFG_DATA_W  config data
- cfg_wstrb  out  1  write enable, equal to cfg_valid
- run  out  1  one-cycle start pulse to read unit
- done  in  1  read-unit done (level)
- busy  out  1  exec_busy OR FIFO non-empty
- sync_irq  out  1  one-cycle pulse when a SYNC completes
- run_count  out  16  RUNs issued, wraps at 65535->0
- err  out  1  sticky: reserved op popped

Behaviour:
- **Reset:** all outputs 0 except cmd_ready=1. FIFO empty, exec_busy=0, mask counter 0.
- **Handshake:**
  - Push on cmd_valid & cmd_ready at an edge; cmd_ready = !full.
  - Fall-through head; pop and push in the same cycle are allowed.
  - A full FIFO accepts no push in the cycle it pops; cmd_ready rises the cycle after the pop.
- **Registered outputs:** cfg_* / run / sync_irq are registered. Entry accepted at edge E into an empty idle FIFO drives its action during the cycle after edge E+1.
- **Dispatch (one head decision per cycle):**
  - WRITE: always issues. cfg_valid=cfg_wstrb=1 for exactly one cycle with head addr/data; pop. Back-to-back WRITEs give one write per cycle, ignoring exec_busy.
  - RUN: if exec_busy, stall (no pop, outputs 0). Else run=1 one cycle; pop; exec_busy<=1; mask<=DONE_MASK; run_count++.
  - SYNC: stall while exec_busy. Else pop; sync_irq=1 one cycle.
  - Reserved (11): pop, no bus action, err<=1.
- **exec tracker:**
  - mask decrements to 0 each cycle while nonzero.
  - exec_busy clears at the edge where mask==0 and done==1.
  - A RUN issuing in that same cycle is still stalled; it issues the next cycle.
- cfg_valid and run are never high in the same cycle; only one head decision is made per cycle.
- **clear:**
  - Next edge: FIFO emptied, all pending head actions dropped, cfg_valid/run/sync_irq forced 0, run_count=0, err=0.
  - exec_busy and mask are NOT cleared. A read-unit run in flight is still tracked, and a later RUN waits for its done.
- clear and cmd_valid in the same cycle: clear wins, push discarded.
- rst asserted mid-operation: everything returns to reset state at the next edge, including exec_busy.
- run_count wraps modulo 2^16 with no flag.

Test Plan:
- **Basic:** reset, push WRITE(a=3,d=0x1000), WRITE(a=4,d=0x40), RUN; done held 1 -> cfg_valid on two consecutive cycles (3/0x1000, 4/0x40), run pulse next cycle, run_count=1, busy=1 until done seen after mask.
- **Ping-pong:** RUN, WRITE x3, RUN with done low for 50 cycles after first run -> 3 writes appear immediately after first run; second run delayed until cycle after done rises; exactly 2 run pulses.
- **Done masking:** done stuck 1 throughout; RUN, RUN -> second run is exactly DONE_MASK+2 cycles after first (mask 2 cycles, clear edge, issue).
- **Full/backpressure:** hold done=0, push RUN, RUN, then 15 WRITEs -> cmd_ready=0 after 16 entries held; release done -> FIFO drains, cmd_ready rises cycle after first pop, all writes delivered in order.
- **SYNC:** RUN, SYNC with done rising 20 cycles later -> sync_irq single pulse the cycle after exec_busy clears; reserved op -> err=1 sticky, no cfg_valid.
- **clear mid-run:** RUN issued, done=0, push 5 WRITEs, assert clear -> no further cfg_valid, run_count=0, busy stays 1 until done; new RUN after clear waits for done.
